// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ            = 8;
    localparam int unsigned IDX_W            = 3;
    localparam int unsigned MAX_HOLD_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/rr_prio_enc8.sv
// Rotating-priority 8-to-3 encoder: the first set bit of (req & mask),
// searched from ptr upwards with wrap, wins. Purely combinational.
module rr_prio_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        masked = req & mask;
        rot    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = masked[IDX_W'(i) + ptr];
        end
        off = '0;
        // Descending scan so the lowest rotated position wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        win_idx = off + ptr;
        win_vld = |masked;
    end

endmodule

// File: rtl/rr_arbiter8to3.sv
// Round-robin arbiter for 8 requesters with registered one-hot and encoded grant.
// Define ARB_TIMEOUT_EN to force release of an owner after MAX_HOLD busy cycles.
module rr_arbiter8to3
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             preempt
);

    if (MAX_HOLD < 2 || MAX_HOLD > 31 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_params
        $error("rr_arbiter8to3: illegal MAX_HOLD/CNT_W combination");
    end

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [N_REQ-1:0] mask;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic             owner_req;
    logic             timeout;
    logic             do_grant;
    logic             go_idle;
    logic [IDX_W-1:0] new_idx;

    assign owner_req = req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q;

    assign timeout = (state_q == BUSY) && owner_req && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
    assign preempt = 1'b0;
`endif

    // On a forced release the current owner (the only set bit of gnt) is masked out.
    assign mask = timeout ? ~gnt : '1;

    rr_prio_enc8 u_enc (
        .req     (req),
        .mask    (mask),
        .ptr     (ptr_q),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    always_comb begin
        do_grant = 1'b0;
        go_idle  = 1'b0;
        unique case (state_q)
            IDLE: do_grant = win_vld;
            BUSY: begin
                do_grant = timeout || (!owner_req && win_vld);
                go_idle  = !owner_req && !win_vld;
            end
            default: go_idle = 1'b1;
        endcase
        // A timeout with no competitor re-grants the same owner.
        new_idx = win_vld ? win_idx : gnt_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt        <= '0;
            gnt_idx    <= '0;
            gnt_vld    <= 1'b0;
            ptr_q      <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            preempt    <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            preempt <= timeout;
`endif
            if (do_grant) begin
                state_q    <= BUSY;
                gnt        <= N_REQ'(1) << new_idx;
                gnt_idx    <= new_idx;
                gnt_vld    <= 1'b1;
                ptr_q      <= new_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
                hold_cnt_q <= '0;
`endif
            end else if (go_idle) begin
                state_q <= IDLE;
                gnt     <= '0;
                gnt_idx <= '0;
                gnt_vld <= 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (state_q == BUSY && hold_cnt_q != '1) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rr_arbiter8to3.sv
// Self-checking bench for rr_arbiter8to3 against a behavioural round-robin model.
// Honours ARB_TIMEOUT_EN the same way as the design.
module tb_rr_arbiter8to3;

    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       preempt;

    int n_checks = 0;
    int n_pass   = 0;

    rr_arbiter8to3 #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = idle), priority start, hold count.
    int m_own  = -1;
    int m_ptr  = 0;
    int m_hcnt = 0;
    bit m_pre  = 1'b0;

    function automatic int m_search(input logic [7:0] r, input int excl);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (m_ptr + k) % 8;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic m_grant(input int w);
        m_own  = w;
        m_ptr  = (w + 1) % 8;
        m_hcnt = 0;
    endtask

    task automatic m_reset();
        m_own  = -1;
        m_ptr  = 0;
        m_hcnt = 0;
        m_pre  = 1'b0;
    endtask

    task automatic m_edge(input logic [7:0] r);
        int w;
        m_pre = 1'b0;
        if (m_own < 0) begin
            w = m_search(r, -1);
            if (w >= 0) m_grant(w);
        end else if (TO_EN && m_hcnt == MAX_HOLD - 1 && r[m_own]) begin
            w = m_search(r, m_own);
            m_grant(w >= 0 ? w : m_own);
            m_pre = 1'b1;
        end else if (r[m_own]) begin
            if (m_hcnt < 31) m_hcnt++;
        end else begin
            w = m_search(r, -1);
            if (w >= 0) m_grant(w);
            else m_own = -1;
        end
    endtask

    // Expected {gnt, gnt_idx, gnt_vld, preempt}.
    function automatic logic [12:0] m_exp();
        logic [7:0] g;
        logic [2:0] ix;
        g  = (m_own < 0) ? 8'h00 : (8'h01 << m_own);
        ix = (m_own < 0) ? 3'd0 : 3'(m_own);
        return {g, ix, (m_own >= 0), m_pre};
    endfunction

    task automatic step(input logic [7:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
        m_edge(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        do_reset();
        obs = {gnt, gnt_idx, gnt_vld, preempt};
        n_checks++;
        if (obs !== 13'h0) $display("FAIL reset_state: got %h want %h", obs, 13'h0);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(8'h00);
            obs = {gnt, gnt_idx, gnt_vld, preempt};
            n_checks++;
            if (obs !== m_exp()) $display("FAIL idle_stay: got %h want %h", obs, m_exp());
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [12:0] obs;
        do_reset();
        step(8'h08);
        obs = {gnt, gnt_idx, gnt_vld, preempt};
        n_checks++;
        if (obs !== m_exp() || gnt_idx !== 3'd3)
            $display("FAIL basic_grant: got %h want %h", obs, m_exp());
        else n_pass++;
        step(8'h00);
        obs = {gnt, gnt_idx, gnt_vld, preempt};
        n_checks++;
        if (obs !== m_exp() || gnt_vld !== 1'b0)
            $display("FAIL basic_release: got %h want %h", obs, m_exp());
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [12:0] obs;
        logic [7:0]  r;
        int          held;
        int          seq[$];
        int          want[4] = '{0, 7, 0, 7};
        do_reset();
        held = 0;
        for (int c = 0; c < 14; c++) begin
            r = 8'h81;
            if (m_own >= 0 && held >= 2) r[m_own] = 1'b0;
            begin
                int prev;
                prev = m_own;
                step(r);
                if (m_own != prev) begin
                    held = 1;
                    if (m_own >= 0) seq.push_back(m_own);
                end else begin
                    held++;
                end
            end
            obs = {gnt, gnt_idx, gnt_vld, preempt};
            n_checks++;
            if (obs !== m_exp()) $display("FAIL fairness_cycle%0d: got %h want %h", c, obs, m_exp());
            else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (seq.size() <= k || seq[k] != want[k])
                $display("FAIL fairness_order%0d: got %0d want %0d", k,
                         (seq.size() > k) ? seq[k] : -1, want[k]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] obs;
        do_reset();
        step(8'h06);
        obs = {gnt, gnt_idx, gnt_vld, preempt};
        n_checks++;
        if (obs !== m_exp() || gnt_idx !== 3'd1)
            $display("FAIL b2b_first: got %h want %h", obs, m_exp());
        else n_pass++;
        step(8'h04);
        obs = {gnt, gnt_idx, gnt_vld, preempt};
        n_checks++;
        if (obs !== m_exp() || gnt_idx !== 3'd2 || gnt_vld !== 1'b1)
            $display("FAIL b2b_handoff: got %h want %h", obs, m_exp());
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [12:0] obs;
        logic [7:0]  pat[3] = '{8'h80, 8'h03, 8'h02};
        logic [2:0]  want[3] = '{3'd7, 3'd0, 3'd1};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(pat[k]);
            obs = {gnt, gnt_idx, gnt_vld, preempt};
            n_checks++;
            if (obs !== m_exp() || gnt_idx !== want[k])
                $display("FAIL wrap_%0d: got %h want %h", k, obs, m_exp());
            else n_pass++;
        end
    endtask

    task automatic test_hold(input logic [7:0] r);
        logic [12:0] obs;
        int          n_pre;
        do_reset();
        n_pre = 0;
        for (int c = 0; c < 17; c++) begin
            step(r);
            if (preempt === 1'b1) n_pre++;
            obs = {gnt, gnt_idx, gnt_vld, preempt};
            n_checks++;
            if (obs !== m_exp()) $display("FAIL hold_%h_c%0d: got %h want %h", r, c, obs, m_exp());
            else n_pass++;
        end
        // 17 cycles with MAX_HOLD=4: forced releases after cycles 4, 8, 12, 16.
        n_checks++;
        if (n_pre != (TO_EN ? 4 : 0))
            $display("FAIL hold_%h_preempts: got %0d want %0d", r, n_pre, TO_EN ? 4 : 0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [12:0] obs;
        do_reset();
        step(8'h0c);
        step(8'h0c);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        obs = {gnt, gnt_idx, gnt_vld, preempt};
        n_checks++;
        if (obs !== 13'h0) $display("FAIL async_reset: got %h want %h", obs, 13'h0);
        else n_pass++;
        @(negedge clk);
        req   = 8'h00;
        rst_n = 1'b1;
        step(8'h20);
        obs = {gnt, gnt_idx, gnt_vld, preempt};
        n_checks++;
        if (obs !== m_exp() || gnt_idx !== 3'd5)
            $display("FAIL async_regrant: got %h want %h", obs, m_exp());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [12:0] obs;
        logic [7:0]  r;
        int          errs;
        do_reset();
        r    = 8'($urandom);
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 31) == 0) r = 8'h00;
            step(r);
            obs = {gnt, gnt_idx, gnt_vld, preempt};
            n_checks++;
            if (obs !== m_exp()) begin
                if (errs < 10)
                    $display("FAIL random_c%0d: req %h got %h want %h", c, r, obs, m_exp());
                errs++;
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_back_to_back();
        test_wrap();
        test_hold(8'h11);
        test_hold(8'h01);
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
